exec_muldiv_unit: RTL and testbench



---
 rtl/exec_muldiv_unit.sv | 237 +++++++++++++++++++++++
 tb/tb_exec_muldiv_unit.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_muldiv_unit.sv
// exec_muldiv_unit: iterative RV32M/RV64M multiply/divide execute unit.
// Shift-add multiply and restoring divide, UNROLL bits per cycle, with a
// valid/ready result handshake and pipeline flush.
// Optional macro MULDIV_REM_CACHE_EN adds a single-entry divide result cache
// so a DIV followed by the matching REM (or vice versa) completes in one cycle.
module exec_muldiv_unit #(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [2:0]      i_op,
    input  logic [4:0]      i_rd,
    input  logic [XLEN-1:0] i_rs1_data,
    input  logic [XLEN-1:0] i_rs2_data,
    input  logic            i_flush,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [4:0]      o_rd,
    output logic [XLEN-1:0] o_res,
    output logic            o_busy
);
    localparam int ITER = XLEN / UNROLL;
    localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
    state_t state, next_state;

    logic [2:0]        op_q;
    logic [2*XLEN-1:0] acc, step_acc;
    logic [XLEN-1:0]   opnd;
    logic [CW-1:0]     cnt;
    logic              neg_res, neg_rem;
    logic              accept, last;

    logic              in_mul, in_div, a_signed, b_signed, neg_a, neg_b;
    logic              div_zero, div_ovf, special;
    logic [XLEN-1:0]   a_mag, b_mag, special_res;
    logic              cache_hit;
    logic [XLEN-1:0]   cache_res;

    logic [XLEN:0]     rem_try, diff, sum;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, final_res;

    // Classify the incoming op, take operand magnitudes and resolve divide special cases
    always_comb begin
        in_mul   = ~i_op[2];
        in_div   = i_op[2];
        a_signed = (i_op == 3'd1) || (i_op == 3'd2) || (i_op == 3'd4) || (i_op == 3'd6);
        b_signed = (i_op == 3'd1) || (i_op == 3'd4) || (i_op == 3'd6);
        neg_a    = a_signed & i_rs1_data[XLEN-1];
        neg_b    = b_signed & i_rs2_data[XLEN-1];
        a_mag    = neg_a ? -i_rs1_data : i_rs1_data;
        b_mag    = neg_b ? -i_rs2_data : i_rs2_data;
        div_zero = (i_rs2_data == '0);
        div_ovf  = ~i_op[0] && (i_rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (i_rs2_data == '1);
        special  = in_div && (div_zero || div_ovf);
        if (div_zero) begin
            special_res = i_op[1] ? i_rs1_data : '1;
        end else begin
            special_res = i_op[1] ? '0 : i_rs1_data;
        end
    end

    // One iteration step: UNROLL shift-add or restoring-subtract bits on the shared accumulator
    always_comb begin
        step_acc = acc;
        rem_try  = '0;
        diff     = '0;
        sum      = '0;
        for (int i = 0; i < UNROLL; i++) begin
            if (state == DIV) begin
                rem_try = {step_acc[2*XLEN-1:XLEN], step_acc[XLEN-1]};
                diff    = rem_try - {1'b0, opnd};
                if (!diff[XLEN]) begin
                    step_acc = {diff[XLEN-1:0], step_acc[XLEN-2:0], 1'b1};
                end else begin
                    step_acc = {rem_try[XLEN-1:0], step_acc[XLEN-2:0], 1'b0};
                end
            end else begin
                sum      = {1'b0, step_acc[2*XLEN-1:XLEN]} + (step_acc[0] ? {1'b0, opnd} : '0);
                step_acc = {sum, step_acc[XLEN-1:1]};
            end
        end
    end

    // Sign-correct the final accumulator and pick the half or field the op returns
    always_comb begin
        prod_fix = neg_res ? -step_acc : step_acc;
        quo_fix  = neg_res ? -step_acc[XLEN-1:0] : step_acc[XLEN-1:0];
        rem_fix  = neg_rem ? -step_acc[2*XLEN-1:XLEN] : step_acc[2*XLEN-1:XLEN];
        if (state == MUL) begin
            final_res = (op_q == 3'd0) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        end else begin
            final_res = op_q[1] ? rem_fix : quo_fix;
        end
    end

`ifdef MULDIV_REM_CACHE_EN
    logic            cache_valid, cache_signed;
    logic [XLEN-1:0] cache_a, cache_b, cache_q, cache_r, a_raw, b_raw;

    // A divide of matching signedness and operands can reuse the last iterated result
    always_comb begin
        cache_hit = in_div && cache_valid && (cache_signed == ~i_op[0]) &&
                    (cache_a == i_rs1_data) && (cache_b == i_rs2_data);
        cache_res = i_op[1] ? cache_r : cache_q;
    end

    // Fill the cache when a divide finishes iterating; drop it on flush or a differing divide
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cache_valid  <= 1'b0;
            cache_signed <= 1'b0;
            cache_a      <= '0;
            cache_b      <= '0;
            cache_q      <= '0;
            cache_r      <= '0;
            a_raw        <= '0;
            b_raw        <= '0;
        end else if (i_flush && !(state == DONE && i_ready)) begin
            cache_valid <= 1'b0;
        end else if (accept) begin
            a_raw <= i_rs1_data;
            b_raw <= i_rs2_data;
            if (in_div && !cache_hit) begin
                cache_valid <= 1'b0;
            end
        end else if (state == DIV && last) begin
            cache_valid  <= 1'b1;
            cache_signed <= ~op_q[0];
            cache_a      <= a_raw;
            cache_b      <= b_raw;
            cache_q      <= quo_fix;
            cache_r      <= rem_fix;
        end
    end
`else
    // Without the cache every divide iterates
    always_comb begin
        cache_hit = 1'b0;
        cache_res = '0;
    end
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state selection and handshake outputs; flush always returns to IDLE
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        last       = (cnt == CW'(ITER - 1));
        o_ready    = (state == IDLE);
        o_busy     = (state != IDLE);
        o_valid    = (state == DONE);
        case (state)
            IDLE: begin
                if (i_valid && !i_flush) begin
                    accept = 1'b1;
                    if (in_mul) begin
                        next_state = MUL;
                    end else if (special || cache_hit) begin
                        next_state = DONE;
                    end else begin
                        next_state = DIV;
                    end
                end
            end
            MUL, DIV: begin
                if (last) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (i_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
        if (i_flush) begin
            next_state = IDLE;
        end
    end

    // Latch operands at accept, iterate, and register the result when it is ready
    always_ff @(posedge clk) begin
        if (!rstn) begin
            acc     <= '0;
            opnd    <= '0;
            cnt     <= '0;
            op_q    <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            o_res   <= '0;
            o_rd    <= '0;
        end else if (i_flush) begin
            cnt <= '0;
        end else if (accept) begin
            op_q    <= i_op;
            o_rd    <= i_rd;
            cnt     <= '0;
            neg_res <= (i_op != 3'd0) && (neg_a ^ neg_b);
            neg_rem <= neg_a;
            if (in_mul) begin
                acc  <= {{XLEN{1'b0}}, b_mag};
                opnd <= a_mag;
            end else begin
                acc  <= {{XLEN{1'b0}}, a_mag};
                opnd <= b_mag;
            end
            if (special) begin
                o_res <= special_res;
            end else if (cache_hit) begin
                o_res <= cache_res;
            end
        end else if (state == MUL || state == DIV) begin
            acc <= step_acc;
            if (last) begin
                cnt   <= '0;
                o_res <= final_res;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_exec_muldiv_unit.sv
// tb_exec_muldiv_unit: table vectors, randomized ops against an arithmetic
// reference model, and hand-written flush/reset/backpressure sequences.
module tb_exec_muldiv_unit;
    localparam int XLEN    = 32;
    localparam int ITERLAT = 33;
`ifdef MULDIV_REM_CACHE_EN
    localparam int CLAT = 1;
`else
    localparam int CLAT = ITERLAT;
`endif

    logic        clk;
    logic        rstn;
    logic        i_valid;
    logic        o_ready;
    logic [2:0]  i_op;
    logic [4:0]  i_rd;
    logic [31:0] i_rs1_data;
    logic [31:0] i_rs2_data;
    logic        i_flush;
    logic        o_valid;
    logic        i_ready;
    logic [4:0]  o_rd;
    logic [31:0] o_res;
    logic        o_busy;

    int checks = 0;
    int errors = 0;

    // Reference-model cache state: last divide that completed by iteration
    bit          mc_valid = 1'b0;
    bit          mc_signed = 1'b0;
    logic [31:0] mc_a = '0;
    logic [31:0] mc_b = '0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp_res;
        int          exp_lat;
        string       name;
    } vec_t;

    vec_t vecs[16];

    exec_muldiv_unit #(.XLEN(XLEN), .UNROLL(1)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_op       (i_op),
        .i_rd       (i_rd),
        .i_rs1_data (i_rs1_data),
        .i_rs2_data (i_rs2_data),
        .i_flush    (i_flush),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_rd       (o_rd),
        .o_res      (o_res),
        .o_busy     (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RISC-V M-extension result computed with wide integer arithmetic
    function automatic logic [31:0] refResult(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        logic [63:0] p;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = '0;
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                return 32'(sa / sb);
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                return 32'(sa % sb);
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic bit isSpecial(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        return op[2] && ((b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    function automatic bit modelHit(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_REM_CACHE_EN
        return op[2] && mc_valid && (mc_signed == !op[0]) && (mc_a == a) && (mc_b == b);
`else
        return 1'b0;
`endif
    endfunction

    function automatic int modelLatency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (isSpecial(op, a, b) || modelHit(op, a, b)) return 1;
        return ITERLAT;
    endfunction

    // Update the reference cache after a divide has completed
    task automatic modelCommit(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2] && !modelHit(op, a, b)) begin
            if (isSpecial(op, a, b)) begin
                mc_valid = 1'b0;
            end else begin
                mc_valid  = 1'b1;
                mc_signed = !op[0];
                mc_a      = a;
                mc_b      = b;
            end
        end
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Present one op for a single edge, then scramble inputs to prove operands were latched
    task automatic acceptOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        i_valid    = 1'b1;
        i_op       = op;
        i_rs1_data = a;
        i_rs2_data = b;
        i_rd       = rd;
        @(posedge clk); #1;
        i_valid    = 1'b0;
        i_op       = 3'($urandom);
        i_rs1_data = $urandom;
        i_rs2_data = $urandom;
        i_rd       = 5'($urandom);
    endtask

    task automatic waitValid(output int lat);
        lat = 1;
        while (!o_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] rd, input logic [31:0] exp_res, input int exp_lat,
                                 input string name);
        int lat;
        acceptOp(op, a, b, rd);
        waitValid(lat);
        checkOutput({name, " latency"}, 64'(lat), 64'(exp_lat));
        checkOutput({name, " o_res"}, {32'b0, o_res}, {32'b0, exp_res});
        checkOutput({name, " o_rd"}, {59'b0, o_rd}, {59'b0, rd});
        modelCommit(op, a, b);
        i_ready = 1'b1;
        @(posedge clk); #1;
        i_ready = 1'b0;
    endtask

    initial begin
        int          lat;
        bit          saw;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] pa;
        logic [31:0] pb;
        logic [4:0]  rd;

        vecs[0]  = '{3'd0, 32'd7, 32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB, ITERLAT, "MUL 7*-3"};
        vecs[1]  = '{3'd1, 32'd7, 32'hFFFF_FFFD, 5'd2, 32'hFFFF_FFFF, ITERLAT, "MULH 7*-3"};
        vecs[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFE, ITERLAT, "MULHU max*max"};
        vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFF, ITERLAT, "MULHSU -1*max"};
        vecs[4]  = '{3'd3, 32'h8000_0000, 32'd2, 5'd5, 32'd1, ITERLAT, "MULHU 2^31*2"};
        vecs[5]  = '{3'd4, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFD, ITERLAT, "DIV -7/2"};
        vecs[6]  = '{3'd6, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFF, CLAT, "REM -7%2"};
        vecs[7]  = '{3'd5, 32'd100, 32'd0, 5'd8, 32'hFFFF_FFFF, 1, "DIVU 100/0"};
        vecs[8]  = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'd0, 1, "REM ovf"};
        vecs[9]  = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000, 1, "DIV ovf"};
        vecs[10] = '{3'd7, 32'd100, 32'd0, 5'd11, 32'd100, 1, "REMU 100%0"};
        vecs[11] = '{3'd4, 32'd100, 32'd7, 5'd12, 32'd14, ITERLAT, "DIV 100/7"};
        vecs[12] = '{3'd6, 32'd100, 32'd7, 5'd13, 32'd2, CLAT, "REM 100%7"};
        vecs[13] = '{3'd5, 32'hFFFF_FFFF, 32'd1, 5'd14, 32'hFFFF_FFFF, ITERLAT, "DIVU max/1"};
        vecs[14] = '{3'd7, 32'hFFFF_FFFF, 32'h10, 5'd15, 32'hF, ITERLAT, "REMU max%16"};
        vecs[15] = '{3'd4, 32'd6, 32'hFFFF_FFFE, 5'd16, 32'hFFFF_FFFD, ITERLAT, "DIV 6/-2"};

        rstn       = 1'b0;
        i_valid    = 1'b0;
        i_op       = '0;
        i_rd       = '0;
        i_rs1_data = '0;
        i_rs2_data = '0;
        i_flush    = 1'b0;
        i_ready    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset o_valid", {63'b0, o_valid}, 64'd0);
        checkOutput("reset o_ready", {63'b0, o_ready}, 64'd1);
        checkOutput("reset o_busy", {63'b0, o_busy}, 64'd0);
        checkOutput("reset o_res", {32'b0, o_res}, 64'd0);
        checkOutput("reset o_rd", {59'b0, o_rd}, 64'd0);
        rstn = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd,
                          vecs[i].exp_res, vecs[i].exp_lat, vecs[i].name);
        end

        pa = 32'd1;
        pb = 32'd1;
        for (int n = 0; n < 60; n++) begin
            op = 3'($urandom_range(0, 7));
            rd = 5'($urandom);
            case ($urandom_range(0, 9))
                0: begin a = $urandom; b = 32'd0; end
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2, 3: begin a = pa; b = pb; end
                4: begin a = $urandom_range(0, 1000); b = $urandom_range(1, 20); end
                default: begin a = $urandom; b = $urandom; end
            endcase
            pa = a;
            pb = b;
            applyStimulus(op, a, b, rd, refResult(op, a, b), modelLatency(op, a, b), "random");
        end

        // Backpressure: result holds while i_ready is low, new requests are ignored
        acceptOp(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd21);
        waitValid(lat);
        checkOutput("bp latency", 64'(lat), 64'(ITERLAT));
        for (int k = 0; k < 5; k++) begin
            i_valid    = 1'b1;
            i_op       = 3'($urandom);
            i_rs1_data = $urandom;
            i_rs2_data = $urandom;
            i_rd       = 5'($urandom);
            @(posedge clk); #1;
            checkOutput("bp o_valid", {63'b0, o_valid}, 64'd1);
            checkOutput("bp o_res", {32'b0, o_res}, 64'hFFFF_FFEB);
            checkOutput("bp o_rd", {59'b0, o_rd}, 64'd21);
            checkOutput("bp o_ready", {63'b0, o_ready}, 64'd0);
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(posedge clk); #1;
        i_ready = 1'b0;
        checkOutput("bp release o_ready", {63'b0, o_ready}, 64'd1);
        checkOutput("bp release o_valid", {63'b0, o_valid}, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("bp nothing queued", {63'b0, o_busy}, 64'd0);

        // Flush at iteration cycle 10 of a divide
        acceptOp(3'd4, 32'd201, 32'd9, 5'd22);
        repeat (9) @(posedge clk);
        #1;
        i_flush = 1'b1;
        @(posedge clk); #1;
        i_flush  = 1'b0;
        mc_valid = 1'b0;
        checkOutput("flush o_ready", {63'b0, o_ready}, 64'd1);
        checkOutput("flush o_valid", {63'b0, o_valid}, 64'd0);
        saw = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (o_valid) saw = 1'b1;
        end
        checkOutput("flush no result", {63'b0, saw}, 64'd0);

        // Flush with i_valid in IDLE drops the op and empties the cache
        applyStimulus(3'd4, 32'd300, 32'd7, 5'd23, 32'd42, modelLatency(3'd4, 32'd300, 32'd7), "DIV 300/7");
        i_valid    = 1'b1;
        i_op       = 3'd0;
        i_rs1_data = 32'd3;
        i_rs2_data = 32'd3;
        i_flush    = 1'b1;
        @(posedge clk); #1;
        i_valid  = 1'b0;
        i_flush  = 1'b0;
        mc_valid = 1'b0;
        checkOutput("idle flush o_busy", {63'b0, o_busy}, 64'd0);
        saw = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (o_valid) saw = 1'b1;
        end
        checkOutput("idle flush dropped", {63'b0, saw}, 64'd0);
        applyStimulus(3'd6, 32'd300, 32'd7, 5'd24, 32'd6, ITERLAT, "REM 300%7 after flush");

        // Flush together with i_ready in DONE just completes the handshake
        acceptOp(3'd5, 32'd1000, 32'd9, 5'd25);
        waitValid(lat);
        checkOutput("done flush latency", 64'(lat), 64'(modelLatency(3'd5, 32'd1000, 32'd9)));
        checkOutput("done flush o_res", {32'b0, o_res}, 64'd111);
        modelCommit(3'd5, 32'd1000, 32'd9);
        i_ready = 1'b1;
        i_flush = 1'b1;
        @(posedge clk); #1;
        i_ready = 1'b0;
        i_flush = 1'b0;
        checkOutput("done flush o_valid", {63'b0, o_valid}, 64'd0);
        checkOutput("done flush o_ready", {63'b0, o_ready}, 64'd1);
        applyStimulus(3'd7, 32'd1000, 32'd9, 5'd26, 32'd1, CLAT, "REMU 1000%9");

        // Reset in the middle of a multiply clears every output
        acceptOp(3'd0, 32'd5, 32'd6, 5'd17);
        repeat (5) @(posedge clk);
        #1;
        rstn = 1'b0;
        @(posedge clk); #1;
        mc_valid = 1'b0;
        checkOutput("midrst o_valid", {63'b0, o_valid}, 64'd0);
        checkOutput("midrst o_rd", {59'b0, o_rd}, 64'd0);
        checkOutput("midrst o_res", {32'b0, o_res}, 64'd0);
        checkOutput("midrst o_busy", {63'b0, o_busy}, 64'd0);
        checkOutput("midrst o_ready", {63'b0, o_ready}, 64'd1);
        rstn = 1'b1;
        @(posedge clk); #1;
        applyStimulus(3'd6, 32'd1000, 32'd9, 5'd27, 32'd1, ITERLAT, "REM after reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
